fourbyte_mem_master: RTL and testbench
======================================

# fourbyte_mem_master

Initiator-side sequencer for the four-byte memory array: accepts one 32-bit read or write request over a valid/ready handshake and performs it as four consecutive byte accesses on the memory's `en`/`wr`/`adr`/`data`/`out` port. On reads it assembles the four returned bytes into one word and returns a one-cycle response pulse. It sits between a word-wide client and the four-byte memory, and is the only driver of the memory's control pins.

## Interface
- Parameters: none.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  client request present.
- `req_ready`  out  1  block can accept a request; high only in IDLE.
- `req_wr`  in  1  1 = write word, 0 = read word; sampled at acceptance.
- `req_wdata`  in  [0:31]  write word, bit 0 = MSB; sampled at acceptance.
- `rsp_valid`  out  1  one-cycle completion pulse for read or write.
- `rsp_rdata`  out  [0:31]  assembled read word; valid with `rsp_valid` on reads, holds last value otherwise.
- `mem_en`  out  1  memory enable.
- `mem_wr`  out  1  memory write strobe.
- `mem_adr`  out  [0:1]  byte address.
- `mem_data`  out  [0:7]  write byte to memory.
- `mem_out`  in  [0:7]  read byte from memory, valid one cycle after the address is presented with `mem_en`=1, `mem_wr`=0.

## Operation
- Byte mapping: byte k (k = 0..3) = word bits [8k:8k+7]; byte 0 (MSB) at `mem_adr`=0, byte 3 at `mem_adr`=3.
- States: IDLE, WRITE, READ, READ_LAST, DONE.
- IDLE: `req_ready`=1. On `req_valid`=1, latch `req_wr` and `req_wdata`, clear byte counter to 0, go to WRITE if `req_wr`=1, else READ. `req_valid` with `req_ready`=0 is ignored; the client holds it.
- WRITE: `mem_en`=1, `mem_wr`=1, `mem_adr`=counter, `mem_data`=latched byte[counter]. Counter increments each cycle. After counter 3, go to DONE.
- READ: `mem_en`=1, `mem_wr`=0, `mem_adr`=counter. From the second READ cycle on, capture `mem_out` into byte[counter-1]. After counter 3, go to READ_LAST.
- READ_LAST: `mem_en`=0; capture `mem_out` into byte 3; go to DONE.
- DONE: `rsp_valid`=1 for exactly one cycle. On reads, `rsp_rdata` = assembled word. Go to IDLE.
- Outside WRITE/READ, `mem_en`=0, `mem_wr`=0, `mem_adr`=0, `mem_data`=0. `mem_wr` is never 1 while `mem_en`=0.
- Changes on `req_wr`/`req_wdata` after acceptance have no effect.
- All memory-port and response outputs are registered (no combinational path from `req_*` or `mem_out` to any output).

## Timing
- Request accepted at edge T (IDLE, `req_valid`=1).
- Write: cycles T+1..T+4 drive addresses 0,1,2,3 with `mem_wr`=1. `rsp_valid` in cycle T+5. `req_ready`=1 again at T+6. Next write is accepted at T+6 at the earliest, so the throughput is one word per 6 cycles.
- Read: cycles T+1..T+4 drive addresses 0..3 with `mem_wr`=0. Bytes are captured at the edges ending T+2..T+5. `rsp_valid` and `rsp_rdata` in cycle T+6. `req_ready`=1 at T+7.
- Reset values: state IDLE, counter 0, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `mem_en`=0, `mem_wr`=0, `mem_adr`=0, `mem_data`=0.
- Reset mid-operation: immediate (asynchronous) return to reset values, with no response pulse. Bytes already written stay in memory. A partially assembled read word is discarded.
- `req_valid` asserted in the same cycle that DONE is active is not accepted; it is accepted on the following IDLE cycle.

## Test plan
- Reset then write 0xA1B2C3D4: `mem_adr` 0,1,2,3 with `mem_data` 0xA1,0xB2,0xC3,0xD4 and `mem_en`=`mem_wr`=1 for exactly 4 cycles; `rsp_valid` one pulse at T+5; `req_ready` low T+1..T+5.
- Read after that write, with a behavioral four-byte memory model: addresses 0..3 with `mem_wr`=0; `rsp_rdata`=0xA1B2C3D4 with `rsp_valid` at T+6.
- Back-to-back requests with `req_valid` held high (write 0x00FF00FF, then read): second acceptance at T+6. The read returns 0x00FF00FF. `req_wdata` changed after the first acceptance is not written.
- Assert `rst` asynchronously during the third WRITE cycle: all outputs go to 0 immediately, `req_ready`=1, no `rsp_valid`; memory bytes 0–1 updated, bytes 2–3 unchanged.
- Assert `rst` mid-read, then perform a clean read of 0x5A5A5A5A: the response is 0x5A5A5A5A, with no stale bytes from the aborted read.
- Idle with `req_valid`=0 for 20 cycles: `mem_en`=0, `rsp_valid`=0 throughout; `rsp_rdata` holds its previous value.

Source files
------------

// File: rtl/fourbyte_mem_master.sv
// Word-wide request sequencer for the four-byte memory: splits a 32-bit read or write
// into four byte accesses and reassembles read bytes into one word.
module fourbyte_mem_master (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wr,
   input  logic [0:31] req_wdata,
   output logic        rsp_valid,
   output logic [0:31] rsp_rdata,
   output logic        mem_en,
   output logic        mem_wr,
   output logic [0:1]  mem_adr,
   output logic [0:7]  mem_data,
   input  logic [0:7]  mem_out
);

   typedef enum logic [2:0] {
      StIdle,
      StWrite,
      StRead,
      StReadLast,
      StDone
   } state_e;

   state_e      r_state, w_state_d;
   logic [1:0]  r_cnt, w_cnt_d, w_cnt_inc;
   logic [0:31] r_word, w_word_d;
   logic [0:31] r_rsp_rdata, w_rdata_d;
   logic        r_rsp_valid, w_rsp_valid_d;
   logic        r_req_ready, w_ready_d;
   logic        r_mem_en, w_en_d;
   logic        r_mem_wr, w_wr_d;
   logic [0:1]  r_mem_adr, w_adr_d;
   logic [0:7]  r_mem_data, w_data_d;

   // Byte k occupies word bits [8k:8k+7]; byte 0 is the MSB.
   function automatic logic [0:7] get_byte(input logic [0:31] w, input logic [1:0] k);
      logic [0:7] b;
      case (k)
         2'd0:    b = w[0:7];
         2'd1:    b = w[8:15];
         2'd2:    b = w[16:23];
         default: b = w[24:31];
      endcase
      return b;
   endfunction

   function automatic logic [0:31] set_byte(input logic [0:31] w, input logic [1:0] k,
                                            input logic [0:7] b);
      logic [0:31] r;
      r = w;
      case (k)
         2'd0:    r[0:7]   = b;
         2'd1:    r[8:15]  = b;
         2'd2:    r[16:23] = b;
         default: r[24:31] = b;
      endcase
      return r;
   endfunction

   // Outputs are registered: next-cycle output values are computed alongside the next state.
   always_comb begin
      w_state_d     = r_state;
      w_cnt_d       = r_cnt;
      w_word_d      = r_word;
      w_rdata_d     = r_rsp_rdata;
      w_rsp_valid_d = 1'b0;
      w_ready_d     = 1'b0;
      w_en_d        = 1'b0;
      w_wr_d        = 1'b0;
      w_adr_d       = 2'd0;
      w_data_d      = 8'd0;
      w_cnt_inc     = r_cnt + 2'd1;

      unique case (r_state)
         StIdle: begin
            w_ready_d = 1'b1;
            if (req_valid) begin
               w_word_d  = req_wdata;
               w_cnt_d   = 2'd0;
               w_ready_d = 1'b0;
               w_en_d    = 1'b1;
               if (req_wr) begin
                  w_state_d = StWrite;
                  w_wr_d    = 1'b1;
                  w_data_d  = req_wdata[0:7];
               end else begin
                  w_state_d = StRead;
               end
            end
         end
         StWrite: begin
            w_cnt_d = w_cnt_inc;
            if (r_cnt == 2'd3) begin
               w_state_d     = StDone;
               w_rsp_valid_d = 1'b1;
            end else begin
               w_en_d   = 1'b1;
               w_wr_d   = 1'b1;
               w_adr_d  = w_cnt_inc;
               w_data_d = get_byte(r_word, w_cnt_inc);
            end
         end
         StRead: begin
            w_cnt_d = w_cnt_inc;
            // mem_out lags the address by one cycle, so it belongs to the previous byte.
            if (r_cnt != 2'd0) begin
               w_word_d = set_byte(r_word, r_cnt - 2'd1, mem_out);
            end
            if (r_cnt == 2'd3) begin
               w_state_d = StReadLast;
            end else begin
               w_en_d  = 1'b1;
               w_adr_d = w_cnt_inc;
            end
         end
         StReadLast: begin
            w_word_d      = set_byte(r_word, 2'd3, mem_out);
            w_rdata_d     = w_word_d;
            w_rsp_valid_d = 1'b1;
            w_state_d     = StDone;
         end
         StDone: begin
            w_state_d = StIdle;
            w_ready_d = 1'b1;
         end
         default: begin
            w_state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= StIdle;
         r_cnt       <= 2'd0;
         r_word      <= 32'd0;
         r_rsp_rdata <= 32'd0;
         r_rsp_valid <= 1'b0;
         r_req_ready <= 1'b1;
         r_mem_en    <= 1'b0;
         r_mem_wr    <= 1'b0;
         r_mem_adr   <= 2'd0;
         r_mem_data  <= 8'd0;
      end else begin
         r_state     <= w_state_d;
         r_cnt       <= w_cnt_d;
         r_word      <= w_word_d;
         r_rsp_rdata <= w_rdata_d;
         r_rsp_valid <= w_rsp_valid_d;
         r_req_ready <= w_ready_d;
         r_mem_en    <= w_en_d;
         r_mem_wr    <= w_wr_d;
         r_mem_adr   <= w_adr_d;
         r_mem_data  <= w_data_d;
      end
   end

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign mem_en    = r_mem_en;
   assign mem_wr    = r_mem_wr;
   assign mem_adr   = r_mem_adr;
   assign mem_data  = r_mem_data;

endmodule

// File: tb/tb_fourbyte_mem_master.sv
// Scoreboard bench for fourbyte_mem_master with a behavioral four-byte memory.
module tb_fourbyte_mem_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_wr = 1'b0;
   logic [0:31] req_wdata = 32'd0;
   logic        rsp_valid;
   logic [0:31] rsp_rdata;
   logic        mem_en;
   logic        mem_wr;
   logic [0:1]  mem_adr;
   logic [0:7]  mem_data;
   logic [0:7]  mem_out = 8'd0;

   logic [7:0]  mem [4];
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;

   typedef struct {
      int          cyc;
      logic [31:0] data;
   } exp_t;
   exp_t q[$];

   fourbyte_mem_master dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_wr    (req_wr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .mem_en    (mem_en),
      .mem_wr    (mem_wr),
      .mem_adr   (mem_adr),
      .mem_data  (mem_data),
      .mem_out   (mem_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioral memory: read data appears one cycle after the address.
   initial for (int i = 0; i < 4; i++) mem[i] = 8'h00;
   always @(posedge clk) begin
      if (mem_en && mem_wr) mem[mem_adr] <= mem_data;
      if (mem_en && !mem_wr) mem_out <= mem[mem_adr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // {req_ready, rsp_valid, mem_en, mem_wr, mem_adr, mem_data}
   function automatic logic [31:0] ctrl_vec();
      return {19'd0, req_ready, rsp_valid, mem_en, mem_wr, mem_adr, mem_data};
   endfunction

   function automatic logic [31:0] ctrl_exp(input logic rdy, input logic en, input logic wr,
                                            input logic [1:0] adr, input logic [7:0] d);
      return {19'd0, rdy, 1'b0, en, wr, adr, d};
   endfunction

   always @(negedge clk) begin
      if (mem_wr && !mem_en) chk("wr_without_en", 32'd1, 32'd0);
   end

   // Response monitor: every rsp_valid pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst && rsp_valid) begin
         if (q.size() == 0) begin
            chk("rsp_unexpected", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("rsp_cycle", cyc, e.cyc);
            chk("rsp_rdata", rsp_rdata, e.data);
         end
      end
   end

   // Issue one request; t returns the acceptance edge (the IDLE cycle index).
   task automatic do_req(input logic wr, input logic [31:0] wd, input logic [31:0] exp_rd,
                         input bit hold, input bit push, output int t);
      int n;
      n = 0;
      t = -1;
      @(negedge clk);
      req_valid = 1'b1;
      req_wr    = wr;
      req_wdata = wd;
      while (!req_ready) begin
         @(negedge clk);
         n++;
         if (n > 50) begin
            chk("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
         end
      end
      t = cyc;
      if (push) q.push_back('{cyc: t + (wr ? 5 : 6), data: exp_rd});
      @(posedge clk);
      #1;
      if (!hold) req_valid = 1'b0;
      req_wr    = ~wr;
      req_wdata = ~wd;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         chk("rsp_timeout", q.size(), 32'd0);
         q.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required finish");
      $fatal(1, "timeout");
   end

   initial begin
      int          t, t1, t2;
      logic [31:0] w;
      logic [1:0]  ka;

      repeat (2) @(negedge clk);
      chk("reset_ctrl", ctrl_vec(), ctrl_exp(1'b1, 1'b0, 1'b0, 2'd0, 8'h00));
      chk("reset_rdata", rsp_rdata, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Write 0xA1B2C3D4 and trace the byte accesses.
      w = 32'hA1B2C3D4;
      do_req(1'b1, w, 32'd0, 1'b0, 1'b1, t);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         ka = k[1:0];
         chk("wr_trace", ctrl_vec(), ctrl_exp(1'b0, 1'b1, 1'b1, ka, 8'((w >> (24 - 8 * k)))));
      end
      @(negedge clk);
      chk("wr_done_ctrl", {31'd0, mem_en | req_ready}, 32'd0);
      @(negedge clk);
      chk("wr_ready_again", {31'd0, req_ready}, 32'd1);
      drain();
      chk("mem_after_wr", {mem[0], mem[1], mem[2], mem[3]}, 32'hA1B2C3D4);

      // Read it back and trace the addresses.
      do_req(1'b0, 32'h0, 32'hA1B2C3D4, 1'b0, 1'b1, t);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         ka = k[1:0];
         chk("rd_trace", ctrl_vec(), ctrl_exp(1'b0, 1'b1, 1'b0, ka, 8'h00));
      end
      drain();

      // Back-to-back write then read with req_valid held; wdata garbled after acceptance.
      do_req(1'b1, 32'h00FF00FF, 32'hA1B2C3D4, 1'b1, 1'b1, t1);
      do_req(1'b0, 32'hFFFFFFFF, 32'h00FF00FF, 1'b0, 1'b1, t2);
      chk("b2b_accept_gap", t2 - t1, 32'd6);
      drain();

      // Asynchronous reset in the third write cycle.
      do_req(1'b1, 32'hDEADBEEF, 32'd0, 1'b0, 1'b0, t);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_wr_ctrl", ctrl_vec(), ctrl_exp(1'b1, 1'b0, 1'b0, 2'd0, 8'h00));
      chk("rst_wr_rdata", rsp_rdata, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("mem_after_rst", {mem[0], mem[1], mem[2], mem[3]}, 32'hDEAD00FF);

      // Reset mid-read, then a clean read of new data.
      do_req(1'b1, 32'h12345678, 32'd0, 1'b0, 1'b1, t);
      drain();
      do_req(1'b0, 32'h0, 32'd0, 1'b0, 1'b0, t);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_rd_ctrl", ctrl_vec(), ctrl_exp(1'b1, 1'b0, 1'b0, 2'd0, 8'h00));
      @(negedge clk);
      rst = 1'b0;
      do_req(1'b1, 32'h5A5A5A5A, 32'd0, 1'b0, 1'b1, t);
      drain();
      do_req(1'b0, 32'h0, 32'h5A5A5A5A, 1'b0, 1'b1, t);
      drain();

      // Idle: no activity, rsp_rdata holds.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle_ctrl", ctrl_vec(), ctrl_exp(1'b1, 1'b0, 1'b0, 2'd0, 8'h00));
         chk("idle_rdata_hold", rsp_rdata, 32'h5A5A5A5A);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
